k2_sequencer: RTL and testbench

Fetch/execute control unit for the K2 8-bit accumulator datapath.
- Owns the program counter that addresses the 16-entry instruction ROM.
- Latches each 8-bit instruction and decodes it into one-cycle register-write and ALU controls.
- Keeps the carry flag and resolves unconditional and carry-conditional jumps.
- Sits between the instruction ROM and the ra/rb/ro register-ALU datapath.

---
 rtl/k2_pkg.sv | 40 ++++
 rtl/k2_decode.sv | 54 +++++
 rtl/k2_sequencer.sv | 106 ++++++++++
 tb/tb_k2_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/k2_pkg.sv
// ============================================================================
// k2_pkg : shared types and decode helpers for the K2 sequencer. Rev 1.0
// ============================================================================
`default_nettype none

package k2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  typedef struct packed {
    logic       j;
    logic       c;
    logic [1:0] d;
    logic       r;
    logic       s;
    logic [1:0] imm2;
  } instr_t;

  localparam logic [1:0] D_RA   = 2'b00;
  localparam logic [1:0] D_RB   = 2'b01;
  localparam logic [1:0] D_RO   = 2'b10;
  localparam logic [1:0] D_NONE = 2'b11;

  // The jump target and imm3 overlap the R/S bits of the same byte.
  function automatic logic [3:0] jump_target(input instr_t ir);
    return {ir.r, ir.s, ir.imm2};
  endfunction

  function automatic logic [2:0] imm3(input instr_t ir);
    return {ir.s, ir.imm2};
  endfunction

endpackage

`default_nettype wire

// File: rtl/k2_decode.sv
// ============================================================================
// k2_decode : combinational IR + state decode into datapath strobes. Rev 1.0
// ============================================================================
`default_nettype none

module k2_decode
  import k2_pkg::*;
(
  input  state_t     state,
  input  instr_t     ir,
  input  logic       carry_flag,
  output logic       ra_we,
  output logic       rb_we,
  output logic       ro_we,
  output logic       alu_sub,
  output logic       sel_imm,
  output logic [2:0] imm,
  output logic       jump_taken,
  output logic       carry_upd
);

  always_comb begin
    ra_we      = 1'b0;
    rb_we      = 1'b0;
    ro_we      = 1'b0;
    alu_sub    = 1'b0;
    sel_imm    = 1'b0;
    imm        = 3'b000;
    jump_taken = 1'b0;
    carry_upd  = 1'b0;
    if (state == EXEC) begin
      sel_imm = ir.r;
      alu_sub = ir.s;
      imm     = imm3(ir);
      if (ir.j) begin
        jump_taken = 1'b1;
      end else if (ir.c) begin
        jump_taken = carry_flag;
      end else begin
        case (ir.d)
          D_RA:    ra_we = 1'b1;
          D_RB:    rb_we = 1'b1;
          D_RO:    ro_we = 1'b1;
          default: ;
        endcase
        // Only adder results into ra/rb produce a meaningful carry.
        carry_upd = ((ir.d == D_RA) || (ir.d == D_RB)) && !ir.r;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/k2_sequencer.sv
// ============================================================================
// k2_sequencer : K2 fetch/execute control (PC, IR, carry, FSM); K2_STEP_EN adds
// a single-step input. Rev 1.0
// ============================================================================
`default_nettype none

module k2_sequencer
  import k2_pkg::*;
#(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned INSTR_W  = 8,
  parameter int unsigned PC_RESET = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
`ifdef K2_STEP_EN
  input  logic               step,
`endif
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               alu_carry,
  output logic               ra_we,
  output logic               rb_we,
  output logic               ro_we,
  output logic               alu_sub,
  output logic               sel_imm,
  output logic [2:0]         imm,
  output logic               carry_flag,
  output logic               halted,
  output logic               busy
);

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(PC_RESET);
  localparam logic [ADDR_W-1:0] PC_INC  = ADDR_W'(1);

  state_t            state;
  state_t            state_nxt;
  instr_t            ir;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] target;
  logic              jump_taken;
  logic              carry_upd;
  logic              step_req;

`ifdef K2_STEP_EN
  assign step_req = step;
`else
  assign step_req = 1'b0;
`endif

  k2_decode u_decode (
    .state      (state),
    .ir         (ir),
    .carry_flag (carry_flag),
    .ra_we      (ra_we),
    .rb_we      (rb_we),
    .ro_we      (ro_we),
    .alu_sub    (alu_sub),
    .sel_imm    (sel_imm),
    .imm        (imm),
    .jump_taken (jump_taken),
    .carry_upd  (carry_upd)
  );

  assign target   = ADDR_W'(jump_target(ir));
  assign rom_addr = pc;
  assign busy     = (state == FETCH) || (state == EXEC);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (run || step_req) state_nxt = FETCH;
      FETCH: state_nxt = EXEC;
      EXEC: begin
        // A taken jump onto itself can never make progress: park in HALT.
        if (jump_taken && (target == pc)) state_nxt = HALT;
        else if (run)                     state_nxt = FETCH;
        else                              state_nxt = IDLE;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= PC_INIT;
      ir         <= '0;
      carry_flag <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == FETCH) ir <= instr_t'(rom_data[7:0]);
      if (state == EXEC) begin
        pc <= jump_taken ? target : pc + PC_INC;
        if (carry_upd) carry_flag <= alu_carry;
      end
      if (state_nxt == HALT) halted <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_k2_sequencer.sv
// ============================================================================
// tb_k2_sequencer : scoreboard bench for k2_sequencer (K2_STEP_EN aware). Rev 1.0
// ============================================================================
`default_nettype none

module tb_k2_sequencer;

  typedef struct packed {
    logic [3:0] addr;
    logic [2:0] we;
    logic       sel;
    logic       sub;
    logic [2:0] imm;
    logic       cf;
    logic       hlt;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       alu_carry;
  logic       carry_mode = 1'b0;
`ifdef K2_STEP_EN
  logic       step = 1'b0;
`endif
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic       ra_we, rb_we, ro_we, alu_sub, sel_imm, carry_flag, halted, busy;
  logic [2:0] imm;
  logic [7:0] rom [16];

  int   checks = 0;
  int   failures = 0;
  rec_t exp_q[$];
  rec_t mon_act;
  rec_t mon_exp;

  localparam logic [2:0] W_NONE = 3'b000;
  localparam logic [2:0] W_RA   = 3'b100;
  localparam logic [2:0] W_RB   = 3'b010;
  localparam logic [2:0] W_RO   = 3'b001;

  always #5 clk = ~clk;

  assign rom_data  = rom[rom_addr];
  // Datapath stand-in: the adder carries out only for rb=rb+ra at address 3.
  assign alu_carry = carry_mode && rb_we && (rom_addr == 4'd3);

  k2_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
`ifdef K2_STEP_EN
    .step       (step),
`endif
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .alu_carry  (alu_carry),
    .ra_we      (ra_we),
    .rb_we      (rb_we),
    .ro_we      (ro_we),
    .alu_sub    (alu_sub),
    .sel_imm    (sel_imm),
    .imm        (imm),
    .carry_flag (carry_flag),
    .halted     (halted),
    .busy       (busy)
  );

  always @(negedge clk) begin
    if (!reset && busy) begin
      mon_act = rec_t'({rom_addr, ra_we, rb_we, ro_we, sel_imm, alu_sub, imm, carry_flag, halted});
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL seq: unexpected busy cycle actual=%h required=none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          failures++;
          $display("FAIL seq: actual=%h required=%h", mon_act, mon_exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One FETCH record followed by the EXEC record of the same instruction.
  task automatic push(input logic [3:0] a, input logic [2:0] we, input logic sel,
                      input logic sub, input logic [2:0] im, input logic cf);
    exp_q.push_back(rec_t'({a, 3'b000, 1'b0, 1'b0, 3'b000, cf, 1'b0}));
    exp_q.push_back(rec_t'({a, we, sel, sub, im, cf, 1'b0}));
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic idle_chk(input string tag, input logic [3:0] a, input logic cf, input logic h);
    @(negedge clk);
    chk({tag, " addr"}, 8'(rom_addr), 8'(a));
    chk({tag, " ctl"}, {ra_we, rb_we, ro_we, sel_imm, alu_sub, imm}, 8'h00);
    chk({tag, " st"}, {5'b0, busy, carry_flag, halted}, {5'b0, 1'b0, cf, h});
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) rom[i] = 8'h30;
    rom[0] = 8'h08; rom[1] = 8'h19; rom[2] = 8'h20; rom[3] = 8'h10; rom[4] = 8'h70;
    rom[5] = 8'h00; rom[6] = 8'h14; rom[7] = 8'h04; rom[8] = 8'h82;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run = 1'b0;
    carry_mode = 1'b0;
    tick(2);
    idle_chk("reset", 4'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    load_prog();

    // Program run with no carry: jc falls through, j 2 loops back.
    do_reset();
    push(0, W_RA, 1, 0, 3'd0, 0); push(1, W_RB, 1, 0, 3'd1, 0);
    push(2, W_RO, 0, 0, 3'd0, 0); push(3, W_RB, 0, 0, 3'd0, 0);
    push(4, W_NONE, 0, 0, 3'd0, 0); push(5, W_RA, 0, 0, 3'd0, 0);
    push(6, W_RB, 0, 1, 3'd4, 0); push(7, W_RA, 0, 1, 3'd4, 0);
    push(8, W_NONE, 0, 0, 3'd2, 0); push(2, W_RO, 0, 0, 3'd0, 0);
    run = 1'b1;
    tick(19);
    run = 1'b0;          // dropped during FETCH of the second pass at PC 2
    tick(2);
    idle_chk("fallthru", 4'd3, 1'b0, 1'b0);

    // Carry set at PC 3 makes jc at PC 4 jump to 0.
    do_reset();
    carry_mode = 1'b1;
    push(0, W_RA, 1, 0, 3'd0, 0); push(1, W_RB, 1, 0, 3'd1, 0);
    push(2, W_RO, 0, 0, 3'd0, 0); push(3, W_RB, 0, 0, 3'd0, 0);
    push(4, W_NONE, 0, 0, 3'd0, 1); push(0, W_RA, 1, 0, 3'd0, 1);
    run = 1'b1;
    tick(11);
    run = 1'b0;
    tick(2);
    idle_chk("jc_taken", 4'd1, 1'b1, 1'b0);

    // Asynchronous reset in the middle of the rb=1 EXEC.
    do_reset();
    push(0, W_RA, 1, 0, 3'd0, 0); push(1, W_RB, 1, 0, 3'd1, 0);
    run = 1'b1;
    tick(4);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst addr", 8'(rom_addr), 8'h00);
    chk("async_rst ctl", {ra_we, rb_we, ro_we, sel_imm, alu_sub, imm}, 8'h00);
    chk("async_rst busy", {7'b0, busy}, 8'h00);
    run = 1'b0;

    // Jump-to-self at PC 2 halts; run toggling is ignored.
    rom[2] = 8'hB2;
    do_reset();
    push(0, W_RA, 1, 0, 3'd0, 0); push(1, W_RB, 1, 0, 3'd1, 0);
    push(2, W_NONE, 0, 0, 3'd2, 0);
    run = 1'b1;
    tick(7);
    idle_chk("halt", 4'd2, 1'b0, 1'b1);
    run = 1'b0;
    tick(3);
    run = 1'b1;
    tick(3);
    idle_chk("halt_hold", 4'd2, 1'b0, 1'b1);

    // All-NOP ROM: no enables, PC wraps 15 -> 0.
    for (int i = 0; i < 16; i++) rom[i] = 8'h30;
    do_reset();
    for (int i = 0; i < 16; i++) push(4'(i), W_NONE, 0, 0, 3'd0, 0);
    push(0, W_NONE, 0, 0, 3'd0, 0);
    run = 1'b1;
    tick(33);
    run = 1'b0;
    tick(2);
    idle_chk("wrap", 4'd1, 1'b0, 1'b0);

`ifdef K2_STEP_EN
    // Single-step two instructions; a step during EXEC is ignored.
    load_prog();
    do_reset();
    push(0, W_RA, 1, 0, 3'd0, 0);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(2);
    idle_chk("step0", 4'd1, 1'b0, 1'b0);
    push(1, W_RB, 1, 0, 3'd1, 0);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(1);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(2);
    idle_chk("step1", 4'd2, 1'b0, 1'b0);
`endif

    chk("scoreboard_empty", 8'(exp_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
